reset_sequencer: RTL

Ordered reset-release controller for multi-domain designs. It synchronizes the board reset and a PLL lock indication into `sys_clk`, then releases `NUM_STAGES` downstream reset outputs one at a time with a programmed spacing. It re-sequences on PLL lock loss or a software request. It sits at the top of the clock/reset tree, ahead of the per-domain reset synchronizers.

---
 rtl/rst_seq_pkg.sv | 14 +
 rtl/bit_sync_2ff.sv | 23 ++
 rtl/reset_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer slice.
package rst_seq_pkg;

   localparam int unsigned RST_SEQ_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_ASSERT    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD      = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_DONE      = 3'd4
   } rst_seq_state_e;

endpackage

// File: rtl/bit_sync_2ff.sv
// Single-bit multi-flop synchronizer, asynchronously cleared to 0.
module bit_sync_2ff
   import rst_seq_pkg::*;
(
   input  logic sys_clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [RST_SEQ_SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[RST_SEQ_SYNC_STAGES-2:0], din};
      end
   end

   assign dout = sync_q[RST_SEQ_SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset-release controller: synchronizes rst_n and PLL lock, then releases stages in order.
// Optional per-stage ack gating is enabled by defining RST_SEQ_ACK_EN.
module reset_sequencer
   import rst_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES   = 4,
   parameter int unsigned HOLD_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT = 1024
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_ack,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic                  seq_done,
   output logic                  timeout_err
);

   localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
   localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned KW = $clog2(NUM_STAGES + 1);

   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
   localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);

   // Internal reset: asynchronous assert, release after the synchronizer depth.
   logic [RST_SEQ_SYNC_STAGES-1:0] rst_sync_q;
   logic                           rst_int_n;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[RST_SEQ_SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[RST_SEQ_SYNC_STAGES-1];

   logic lock_s;

   bit_sync_2ff u_lock_sync (
      .sys_clk (sys_clk),
      .rst_n   (rst_int_n),
      .din     (pll_locked),
      .dout    (lock_s)
   );

`ifdef RST_SEQ_ACK_EN
   logic [NUM_STAGES-1:0] ack_s;

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_ack_sync
      bit_sync_2ff u_ack_sync (
         .sys_clk (sys_clk),
         .rst_n   (rst_int_n),
         .din     (stage_ack[g]),
         .dout    (ack_s[g])
      );
   end
`else
   logic unused_stage_ack;
   assign unused_stage_ack = ^stage_ack;
`endif

   rst_seq_state_e        state_q, state_d;
   logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
   logic [TW-1:0]         to_cnt_q, to_cnt_d;
   logic [KW-1:0]         k_q, k_d;
   logic                  err_q, err_d;
   logic [NUM_STAGES-1:0] out_q, out_d;
   logic [NUM_STAGES-1:0] k_mask;
   logic                  in_seq;
   logic                  hold_last;

   always_comb begin
      k_mask = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         k_mask[i] = (k_q == KW'(i));
      end
   end

   assign in_seq    = (state_q != ST_ASSERT) && (state_q != ST_WAIT_LOCK);
   assign hold_last = (hold_cnt_q == HOLD_LAST);

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      to_cnt_d   = to_cnt_q;
      k_d        = k_q;
      err_d      = err_q;
      out_d      = out_q;
      if (sw_rst_req) begin
         state_d    = ST_ASSERT;
         hold_cnt_d = '0;
         k_d        = '0;
         out_d      = '0;
         err_d      = 1'b0;
         to_cnt_d   = '0;
      end else if (in_seq && !lock_s) begin
         state_d    = ST_ASSERT;
         hold_cnt_d = '0;
         k_d        = '0;
         out_d      = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               if (hold_last) begin
                  state_d    = ST_WAIT_LOCK;
                  hold_cnt_d = '0;
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1);
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_d    = ST_HOLD;
                  k_d        = '0;
                  hold_cnt_d = '0;
               end else if (to_cnt_q == TO_LAST) begin
                  err_d = 1'b1;
               end else begin
                  to_cnt_d = to_cnt_q + TW'(1);
               end
            end
            ST_HOLD: begin
               if (hold_last) begin
                  hold_cnt_d = '0;
                  out_d      = out_q | k_mask;
                  if (k_q == K_LAST) begin
                     state_d = ST_DONE;
                  end else begin
`ifdef RST_SEQ_ACK_EN
                     state_d = ST_WAIT_ACK;
`else
                     k_d = k_q + KW'(1);
`endif
                  end
               end else begin
                  hold_cnt_d = hold_cnt_q + HW'(1);
               end
            end
`ifdef RST_SEQ_ACK_EN
            // k still names the stage just released; its ack opens the next hold.
            ST_WAIT_ACK: begin
               if (|(ack_s & k_mask)) begin
                  state_d    = ST_HOLD;
                  k_d        = k_q + KW'(1);
                  hold_cnt_d = '0;
               end
            end
`endif
            ST_DONE: begin
            end
            default: begin
               state_d    = ST_ASSERT;
               hold_cnt_d = '0;
               k_d        = '0;
               out_d      = '0;
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= ST_ASSERT;
         hold_cnt_q <= '0;
         to_cnt_q   <= '0;
         k_q        <= '0;
         err_q      <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         to_cnt_q   <= to_cnt_d;
         k_q        <= k_d;
         err_q      <= err_d;
         out_q      <= out_d;
      end
   end

   assign rst_out_n   = out_q;
   assign seq_done    = (state_q == ST_DONE);
   assign timeout_err = err_q;

endmodule
